// File: rtl/spike_buf_pkg.sv
// spike_buf_pkg: default widths and derived sizes shared by the spike FIFO.
package spike_buf_pkg;
   localparam int FLIT_W  = 4;
   localparam int WORD_W  = 32;
   localparam int DEPTH_W = 16;
   localparam int RATIO   = WORD_W / FLIT_W;

   // A single-entry range still needs one bit to be a legal vector
   function automatic int idx_bits(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction

   localparam int LANE_W = idx_bits(RATIO);
   localparam int PTR_W  = idx_bits(DEPTH_W);
   localparam int CNT_W  = $clog2(DEPTH_W * RATIO) + 1;
endpackage

// File: rtl/spike_buf_mem.sv
// spike_buf_mem: dual-port RAM with a lane-enabled flit write port and a registered word read port.
module spike_buf_mem #(
   parameter int FLIT_WIDTH  = 4,
   parameter int WORD_WIDTH  = 32,
   parameter int DEPTH_WORDS = 16,
   parameter int LW          = 3,
   parameter int PW          = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [PW-1:0]         waddr_i,
   input  logic [LW-1:0]         lane_i,
   input  logic [FLIT_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [PW-1:0]         raddr_i,
   output logic [WORD_WIDTH-1:0] rdata_o
);
   logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];
   logic [WORD_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i)
      if (we_i) mem_q[waddr_i][lane_i*FLIT_WIDTH +: FLIT_WIDTH] <= wdata_i;

   always_ff @(posedge clk_i)
      if (rst_i) rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];

   assign rdata_o = rdata_q;
endmodule

// File: rtl/spike_buf.sv
// spike_buf: packs FLIT_WIDTH router flits little-endian into WORD_WIDTH spike words;
// a word becomes readable only once all of its flits have been written.
module spike_buf
   import spike_buf_pkg::*;
#(
   parameter int FLIT_WIDTH  = FLIT_W,
   parameter int WORD_WIDTH  = WORD_W,
   parameter int DEPTH_WORDS = DEPTH_W
) (
   input  logic                  router_clk,
   input  logic                  router_reset,
   input  logic [FLIT_WIDTH-1:0] data,
   input  logic                  wrreq,
   input  logic                  rdreq,
   output logic [WORD_WIDTH-1:0] q,
   output logic                  rdempty,
   output logic                  wrfull
);
   localparam int R   = WORD_WIDTH / FLIT_WIDTH;
   localparam int LW  = idx_bits(R);
   localparam int PW  = idx_bits(DEPTH_WORDS);
   localparam int CW  = $clog2(DEPTH_WORDS * R) + 1;
   localparam int CAP = DEPTH_WORDS * R;

   logic [LW-1:0] lane_q, lane_d;
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] fcnt_q, fcnt_d;
   logic          wr_en, rd_en, lane_last;

   assign rdempty = fcnt_q < CW'(R);
   assign wrfull  = fcnt_q == CW'(CAP);

   always_comb begin
      wr_en     = wrreq && !wrfull;
      rd_en     = rdreq && !rdempty;
      lane_last = lane_q == LW'(R - 1);
      lane_d    = wr_en ? (lane_last ? '0 : lane_q + LW'(1)) : lane_q;
      wptr_d    = wptr_q + PW'(wr_en && lane_last);
      rptr_d    = rptr_q + PW'(rd_en);
      fcnt_d    = fcnt_q + CW'(wr_en) - (rd_en ? CW'(R) : '0);
   end

   always_ff @(posedge router_clk)
      if (router_reset) begin
         lane_q <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         fcnt_q <= '0;
      end else begin
         lane_q <= lane_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         fcnt_q <= fcnt_d;
      end

   spike_buf_mem #(
      .FLIT_WIDTH (FLIT_WIDTH),
      .WORD_WIDTH (WORD_WIDTH),
      .DEPTH_WORDS(DEPTH_WORDS),
      .LW         (LW),
      .PW         (PW)
   ) u_mem (
      .clk_i  (router_clk),
      .rst_i  (router_reset),
      .we_i   (wr_en),
      .waddr_i(wptr_q),
      .lane_i (lane_q),
      .wdata_i(data),
      .re_i   (rd_en),
      .raddr_i(rptr_q),
      .rdata_o(q)
   );
endmodule

// File: tb/tb_spike_buf.sv
// tb_spike_buf: directed vector table plus model-checked streaming, full and wrap-around sequences.
module tb_spike_buf;
   logic        router_clk = 1'b0;
   logic        router_reset = 1'b1;
   logic [3:0]  data = '0;
   logic        wrreq = 1'b0;
   logic        rdreq = 1'b0;
   logic [31:0] q;
   logic        rdempty, wrfull;

   spike_buf dut (
      .router_clk  (router_clk),
      .router_reset(router_reset),
      .data        (data),
      .wrreq       (wrreq),
      .rdreq       (rdreq),
      .q           (q),
      .rdempty     (rdempty),
      .wrfull      (wrfull)
   );

   always #5 router_clk = ~router_clk;

   typedef struct {
      logic        rst, wr, rd;
      logic [3:0]  d;
      logic [31:0] eq;
      logic        ee, ef;
   } vec_t;

   vec_t        tbl[$];
   int          n_cmp = 0, n_fail = 0;
   int          mcnt = 0, mlane = 0, reads = 0;
   logic [31:0] mcur = '0, mq = '0;
   logic [31:0] words[$];

   task automatic add(input logic r, w, rd, input logic [3:0] d, input logic [31:0] eq,
                      input logic ee, ef);
      vec_t v;
      v.rst = r; v.wr = w; v.rd = rd; v.d = d; v.eq = eq; v.ee = ee; v.ef = ef;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Drives one cycle and advances the reference model by the same edge
   task automatic drive(input logic r, w, rd, input logic [3:0] d);
      logic wa, ra;
      router_reset = r; wrreq = w; rdreq = rd; data = d;
      wa = w && mcnt < 128;
      ra = rd && mcnt >= 8;
      @(posedge router_clk);
      #1;
      if (r) begin
         mcnt = 0; mlane = 0; mcur = '0; mq = '0; words.delete();
      end else begin
         if (ra) begin
            mq = words.pop_front();
            mcnt -= 8;
            reads++;
         end
         if (wa) begin
            mcur[mlane*4 +: 4] = d;
            mcnt++;
            mlane++;
            if (mlane == 8) begin
               words.push_back(mcur);
               mcur = '0;
               mlane = 0;
            end
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_q"}, q, mq);
      chk({tag, "_rdempty"}, 32'(rdempty), 32'(mcnt < 8));
      chk({tag, "_wrfull"}, 32'(wrfull), 32'(mcnt == 128));
   endtask

   initial begin
      add(1, 0, 0, 0, 32'h0, 1, 0);
      for (int i = 1; i <= 5; i++) add(0, 1, 0, 4'(i), 32'h0, 1, 0);
      add(1, 1, 1, 4'h6, 32'h0, 1, 0);
      for (int i = 1; i <= 8; i++) add(0, 1, 0, 4'(i), 32'h0, i < 8, 0);
      add(0, 0, 1, 0, 32'h87654321, 1, 0);
      for (int i = 9; i <= 15; i++) add(0, 1, 0, 4'(i), 32'h87654321, 1, 0);
      add(0, 0, 1, 0, 32'h87654321, 1, 0);
      add(0, 1, 0, 4'h0, 32'h87654321, 0, 0);
      add(0, 0, 1, 0, 32'h0FEDCBA9, 1, 0);
      for (int i = 1; i <= 8; i++) add(0, 1, 0, 4'(i), 32'h0FEDCBA9, i < 8, 0);
      for (int i = 0; i <= 6; i++) add(0, 1, 0, 4'(i), 32'h0FEDCBA9, 0, 0);
      add(0, 1, 1, 4'h7, 32'h87654321, 0, 0);
      add(0, 0, 1, 0, 32'h76543210, 1, 0);
      add(0, 0, 1, 0, 32'h76543210, 1, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].d);
         chk($sformatf("vec%0d_q", i), q, tbl[i].eq);
         chk($sformatf("vec%0d_rdempty", i), 32'(rdempty), 32'(tbl[i].ee));
         chk($sformatf("vec%0d_wrfull", i), 32'(wrfull), 32'(tbl[i].ef));
      end

      drive(1, 0, 0, 0);
      reads = 0;
      for (int c = 0; c < 30; c++) begin
         drive(0, c < 24, !rdempty, 4'(c * 3 + 1));
         check_model("stream");
      end
      chk("stream_reads", 32'(reads), 32'd3);

      drive(1, 0, 0, 0);
      for (int i = 0; i < 128; i++) begin
         drive(0, 1, 0, 4'(i + i / 8));
         check_model("fill");
      end
      chk("full_flag", 32'(wrfull), 32'd1);
      drive(0, 1, 0, 4'hF);
      check_model("drop");
      drive(0, 0, 1, 0);
      check_model("release");
      chk("release_wrfull", 32'(wrfull), 32'd0);
      for (int i = 0; i < 15; i++) begin
         drive(0, 0, 1, 0);
         check_model("drain");
      end
      chk("drain_rdempty", 32'(rdempty), 32'd1);
      chk("drain_q", q, 32'hEDCBA987);

      drive(1, 0, 0, 0);
      reads = 0;
      for (int c = 0; c < 380; c++) begin
         drive(0, c < 320, c >= 320 || $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
         check_model("wrap");
      end
      chk("wrap_reads", 32'(reads), 32'd40);
      chk("wrap_rdempty", 32'(rdempty), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
